// File: rtl/light_hash_gen.sv
// Byte-serial lightweight hash: AES S-box mixing over an N-byte lane state, ROUNDS rounds per byte.
// Optional macro LIGHT_HASH_LEN_PAD_EN adds one length-padding byte compression at TAIL.
module light_hash_gen #(
    parameter int DIGEST_BYTES = 8,
    parameter int ROUNDS       = 16,
    parameter int LEN_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [1:0]                in_cmd,
    input  logic [7:0]                in_byte,
    output logic                      in_ready,
    output logic [8*DIGEST_BYTES-1:0] digest,
    output logic                      digest_ready,
    output logic [LEN_W-1:0]          msg_len,
    output logic                      cmd_err
);

    localparam int N = DIGEST_BYTES;
    localparam logic [1:0] CMD_HEAD = 2'b00;
    localparam logic [1:0] CMD_TAIL = 2'b01;
    localparam logic [1:0] CMD_MSG  = 2'b10;
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    state_t         state;
    logic [8*N-1:0] h_q;
    logic [8*N-1:0] h_next;
    logic [8*N-1:0] iv;
    logic [7:0]     m_byte;
    logic [7:0]     rnd;
`ifdef LIGHT_HASH_LEN_PAD_EN
    logic           pad_q;
`endif

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is decoded from the state register only, never from in_valid.
    assign in_ready = (state != ST_ROUND);

    always_comb begin
        iv = '0;
        for (int i = 0; i < N; i++) begin
            iv[8*i +: 8] = SBOX[i[7:0]];
        end
    end

    // One round: every lane mixes its right-hand neighbour through the S-box.
    always_comb begin
        h_next = '0;
        for (int i = 0; i < N; i++) begin
            h_next[8*i +: 8] = SBOX[h_q[8*((i + 1) % N) +: 8] ^ m_byte ^ rnd]
                             ^ {h_q[8*i +: 7], h_q[8*i + 7]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            h_q          <= '0;
            m_byte       <= '0;
            rnd          <= '0;
            digest       <= '0;
            digest_ready <= 1'b0;
            msg_len      <= '0;
            cmd_err      <= 1'b0;
`ifdef LIGHT_HASH_LEN_PAD_EN
            pad_q        <= 1'b0;
`endif
        end else begin
            cmd_err <= 1'b0;
            case (state)
                ST_IDLE, ST_OPEN: begin
                    if (in_valid) begin
                        case (in_cmd)
                            CMD_HEAD: begin
                                h_q          <= iv;
                                msg_len      <= '0;
                                digest_ready <= 1'b0;
                                state        <= ST_OPEN;
                            end
                            CMD_MSG: begin
                                if (state == ST_OPEN) begin
                                    m_byte  <= in_byte;
                                    rnd     <= '0;
                                    msg_len <= msg_len + LEN_W'(1);
                                    state   <= ST_ROUND;
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            CMD_TAIL: begin
                                if (state == ST_OPEN) begin
`ifdef LIGHT_HASH_LEN_PAD_EN
                                    // Length byte (mod 256) is absorbed as a final padding byte.
                                    m_byte <= msg_len[7:0];
                                    rnd    <= '0;
                                    pad_q  <= 1'b1;
                                    state  <= ST_ROUND;
`else
                                    digest       <= h_q;
                                    digest_ready <= 1'b1;
                                    state        <= ST_IDLE;
`endif
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_ROUND: begin
                    h_q <= h_next;
                    rnd <= rnd + 8'd1;
                    if (rnd == LAST_ROUND) begin
                        state <= ST_OPEN;
`ifdef LIGHT_HASH_LEN_PAD_EN
                        if (pad_q) begin
                            digest       <= h_next;
                            digest_ready <= 1'b1;
                            pad_q        <= 1'b0;
                            state        <= ST_IDLE;
                        end
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_light_hash_gen.sv
// Self-checking bench for light_hash_gen; the S-box reference is rebuilt from GF(2^8) arithmetic.
// Defining LIGHT_HASH_LEN_PAD_EN switches the bench to the padded N=4, ROUNDS=1 configuration.
module tb_light_hash_gen;

`ifdef LIGHT_HASH_LEN_PAD_EN
    localparam int N = 4;
    localparam int R = 1;
`else
    localparam int N = 8;
    localparam int R = 16;
`endif
    localparam int LW = 32;

    typedef logic [7:0] byte_q_t [$];

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [1:0]        in_cmd;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [8*N-1:0]    digest;
    logic              digest_ready;
    logic [LW-1:0]     msg_len;
    logic              cmd_err;

    logic [7:0]        sb [256];
    logic [8*N-1:0]    exp_q [$];
    int                checks;
    int                errors;
    int                err_pulses;

    light_hash_gen #(.DIGEST_BYTES(N), .ROUNDS(R), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_cmd       (in_cmd),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .digest       (digest),
        .digest_ready (digest_ready),
        .msg_len      (msg_len),
        .cmd_err      (cmd_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_err) err_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [8*N-1:0] absorb(input logic [8*N-1:0] h_in, input logic [7:0] m);
        logic [8*N-1:0] h, t;
        logic [7:0] nb, cur;
        h = h_in;
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < N; i++) begin
                nb  = h[8*((i + 1) % N) +: 8];
                cur = h[8*i +: 8];
                t[8*i +: 8] = sb[nb ^ m ^ 8'(r)] ^ {cur[6:0], cur[7]};
            end
            h = t;
        end
        return h;
    endfunction

    function automatic logic [8*N-1:0] model(input byte_q_t msg);
        logic [8*N-1:0] h;
        for (int i = 0; i < N; i++) h[8*i +: 8] = sb[i];
        foreach (msg[j]) h = absorb(h, msg[j]);
`ifdef LIGHT_HASH_LEN_PAD_EN
        h = absorb(h, 8'(msg.size()));
`endif
        return h;
    endfunction

    function automatic byte_q_t str_to_q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] c, input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_cmd = c; in_byte = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_cmd = 2'b00; in_byte = 8'h00;
    endtask

    task automatic hash_msg(input byte_q_t msg);
        send(2'b00, 8'h00);
        foreach (msg[j]) send(2'b10, msg[j]);
        exp_q.push_back(model(msg));
        send(2'b01, 8'h00);
    endtask

    task automatic wait_digest();
        int n;
        n = 0;
        while (!digest_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (digest_ready !== 1'b1) begin
            errors++;
            $display("FAIL digest_timeout: digest_ready=%b required 1", digest_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_cmd = 2'b00; in_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (digest !== '0) begin errors++; $display("FAIL reset_digest: got %h required 0", digest); end
        checks++; if (digest_ready !== 1'b0) begin errors++; $display("FAIL reset_digest_ready: got %b required 0", digest_ready); end
        checks++; if (msg_len !== '0) begin errors++; $display("FAIL reset_msg_len: got %0d required 0", msg_len); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b required 0", cmd_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_message();
        byte_q_t empty;
        logic [8*N-1:0] exp;
        hash_msg(empty);
`ifdef LIGHT_HASH_LEN_PAD_EN
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pad_busy: in_ready=%b required 0", in_ready); end
        wait_digest();
        checks++; if (digest === 32'h7b777c63) begin errors++; $display("FAIL pad_changes_iv: got %h required not 7b777c63", digest); end
`else
        checks++; if (digest_ready !== 1'b1) begin errors++; $display("FAIL tail_same_edge: digest_ready=%b required 1", digest_ready); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tail_no_extra: in_ready=%b required 1", in_ready); end
        checks++; if (digest !== 64'hc56f6bf27b777c63) begin errors++; $display("FAIL empty_iv: got %h required c56f6bf27b777c63", digest); end
`endif
        exp = exp_q.pop_front();
        checks++; if (digest !== exp) begin errors++; $display("FAIL empty_model: got %h required %h", digest, exp); end
        checks++; if (msg_len !== '0) begin errors++; $display("FAIL empty_len: got %0d required 0", msg_len); end
    endtask

    task automatic test_round_timing();
        int n;
        logic [8*N-1:0] exp;
        byte_q_t one;
        one.push_back(8'h41);
        send(2'b00, 8'h00);
        send(2'b10, 8'h41);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL round_busy: in_ready=%b required 0", in_ready); end
        checks++; if (msg_len !== 32'd1) begin errors++; $display("FAIL round_len: got %0d required 1", msg_len); end
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != R) begin errors++; $display("FAIL round_cycles: got %0d required %0d", n, R); end
        exp_q.push_back(model(one));
        send(2'b01, 8'h00);
        wait_digest();
        exp = exp_q.pop_front();
        checks++; if (digest !== exp) begin errors++; $display("FAIL round_digest: got %h required %h", digest, exp); end
    endtask

    task automatic test_distinct_strings();
        logic [8*N-1:0] d1, d2, d3, exp;
        hash_msg(str_to_q("AlessandroAndGiacomo")); wait_digest(); d1 = digest;
        exp = exp_q.pop_front();
        checks++; if (d1 !== exp) begin errors++; $display("FAIL str1_model: got %h required %h", d1, exp); end
        hash_msg(str_to_q("AlessandroandGiacomo")); wait_digest(); d2 = digest;
        exp = exp_q.pop_front();
        checks++; if (d2 !== exp) begin errors++; $display("FAIL str2_model: got %h required %h", d2, exp); end
        checks++; if (d1 === d2) begin errors++; $display("FAIL str_differ: got %h required not %h", d2, d1); end
        hash_msg(str_to_q("AlessandroAndGiacomo")); wait_digest(); d3 = digest;
        exp = exp_q.pop_front();
        checks++; if (d3 !== d1) begin errors++; $display("FAIL str_repeat: got %h required %h", d3, d1); end
        checks++; if (msg_len !== 32'd20) begin errors++; $display("FAIL str_len: got %0d required 20", msg_len); end
    endtask

    task automatic test_cmd_err();
        logic [8*N-1:0] d, exp;
        logic [LW-1:0] l;
        int p0;
        byte_q_t one;
        d = digest; l = msg_len; p0 = err_pulses;
        send(2'b10, 8'h33);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_msg_idle: cmd_err=%b required 1", cmd_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL err_msg_state: in_ready=%b required 1", in_ready); end
        send(2'b01, 8'h00);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_tail_idle: cmd_err=%b required 1", cmd_err); end
        checks++; if (digest !== d) begin errors++; $display("FAIL err_digest_hold: got %h required %h", digest, d); end
        checks++; if (digest_ready !== 1'b1) begin errors++; $display("FAIL err_ready_hold: got %b required 1", digest_ready); end
        checks++; if (msg_len !== l) begin errors++; $display("FAIL err_len_hold: got %0d required %0d", msg_len, l); end
        send(2'b00, 8'h00);
        send(2'b11, 8'h77);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_reserved: cmd_err=%b required 1", cmd_err); end
        checks++; if (in_ready !== 1'b1 || msg_len !== '0) begin errors++; $display("FAIL err_reserved_state: in_ready=%b msg_len=%0d required 1/0", in_ready, msg_len); end
        @(posedge clk); #1;
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: cmd_err=%b required 0", cmd_err); end
        checks++; if (err_pulses - p0 != 3) begin errors++; $display("FAIL err_pulses: got %0d required 3", err_pulses - p0); end
        one.push_back(8'h5a);
        send(2'b10, 8'h5a);
        exp_q.push_back(model(one));
        send(2'b01, 8'h00);
        wait_digest();
        exp = exp_q.pop_front();
        checks++; if (digest !== exp) begin errors++; $display("FAIL err_still_open: got %h required %h", digest, exp); end
    endtask

    task automatic test_reset_mid_round();
        logic [8*N-1:0] exp;
        byte_q_t msg;
        send(2'b00, 8'h00);
        send(2'b10, 8'hc3);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || digest !== '0 || digest_ready !== 1'b0 || msg_len !== '0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b digest=%h dr=%b len=%0d err=%b required 1/0/0/0/0",
                     in_ready, digest, digest_ready, msg_len, cmd_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(2'b10, 8'h11);
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL msg_after_reset: cmd_err=%b required 1", cmd_err); end
        msg.push_back(8'h00); msg.push_back(8'hff); msg.push_back(8'h80);
        hash_msg(msg);
        wait_digest();
        exp = exp_q.pop_front();
        checks++; if (digest !== exp) begin errors++; $display("FAIL post_reset_hash: got %h required %h", digest, exp); end
    endtask

    task automatic test_back_to_back();
        logic [8*N-1:0] exp;
        byte_q_t msg;
        int len;
        send(2'b00, 8'h00);
        send(2'b10, 8'hee);
        for (int m = 0; m < 4; m++) begin
            msg.delete();
            len = $urandom_range(0, 6);
            for (int j = 0; j < len; j++) msg.push_back(8'($urandom_range(0, 255)));
            hash_msg(msg);
            wait_digest();
            exp = exp_q.pop_front();
            checks++; if (digest !== exp) begin errors++; $display("FAIL b2b_digest_%0d: got %h required %h", m, digest, exp); end
            checks++; if (msg_len !== LW'(len)) begin errors++; $display("FAIL b2b_len_%0d: got %0d required %0d", m, msg_len, len); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; err_pulses = 0;
        init_sbox();
        test_reset();
        test_empty_message();
        test_round_timing();
        test_distinct_strings();
        test_cmd_err();
        test_reset_mid_round();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_hash_gen.md
LIGHT_HASH_GEN -- requirements
Module: light_hash_gen

Interface
REQ-001 Parameter DIGEST_BYTES, default 8, digest width in bytes N; legal range 2..16.
REQ-002 Parameter ROUNDS, default 16, compression rounds per absorbed byte; legal range 1..255.
REQ-003 Parameter LEN_W, default 32, width of the message byte counter.
REQ-004 Port clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-005 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port in_valid  input  1  command/byte offered.
REQ-007 Port in_cmd  input  2  command: HEAD=00, TAIL=01, MSG=10, 11=reserved.
REQ-008 Port in_byte  input  8  message byte, sampled only with MSG.
REQ-009 Port in_ready  output  1  block can accept a command this cycle.
REQ-010 Port digest  output  8*N  digest; byte i at [8i+7:8i].
REQ-011 Port digest_ready  output  1  digest valid, held until the next accepted HEAD.
REQ-012 Port msg_len  output  LEN_W  bytes absorbed since the last HEAD.
REQ-013 Port cmd_err  output  1  one-cycle pulse on an illegal command.

Function
REQ-014 Transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL NOT depend combinationally on in_valid.
REQ-015 FSM states SHALL be IDLE (no open message), OPEN (awaiting byte/TAIL), ROUND (compressing); in_ready=1 in IDLE/OPEN, 0 in ROUND.
REQ-016 State array H[0..N-1] of bytes; IV SHALL be H[i]=S(i), S = AES forward S-box.
REQ-017 HEAD accepted in any state except ROUND: H<=IV, msg_len<=0, digest_ready<=0, state->OPEN; HEAD in OPEN restarts the message.
REQ-018 MSG accepted in OPEN: latch M=in_byte, r<=0, msg_len<=msg_len+1 (wraps mod 2^LEN_W), state->ROUND.
REQ-019 Each ROUND cycle, all lanes in parallel: H'[i] = S(H[(i+1) mod N] ^ M ^ r) ^ rotl1(H[i]); r increments.
REQ-020 After exactly ROUNDS round cycles, state->OPEN; a MSG accepted at edge k SHALL next see in_ready=1 after edge k+ROUNDS.
REQ-021 TAIL accepted in OPEN without padding: digest<=H, digest_ready<=1, state->IDLE at that same edge.
REQ-022 MSG or TAIL accepted in IDLE, or any reserved command: no state change, cmd_err=1 for one cycle; the transfer SHALL still complete.
REQ-023 digest and digest_ready SHALL stay stable from TAIL completion until the next accepted HEAD.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, H=0, r=0, digest=0, digest_ready=0, msg_len=0, cmd_err=0, in_ready=1.
REQ-025 Reset asserted mid-ROUND SHALL abandon the message; after release, a HEAD is required before MSG is legal.

Configuration
REQ-026 Macro LIGHT_HASH_LEN_PAD_EN defined: TAIL in OPEN SHALL enter ROUND with M=msg_len[7:0], in_ready=0 for ROUNDS cycles, then latch digest, set digest_ready=1, and go IDLE.
REQ-027 Macro LIGHT_HASH_LEN_PAD_EN undefined: TAIL behaves per REQ-021, with zero extra cycles.

Verification
REQ-028 N=8, no pad: reset, HEAD, TAIL -> digest=64'hc56f6bf27b777c63, digest_ready=1, msg_len=0.
REQ-029 ROUNDS=16: MSG 8'h41 accepted at edge k -> in_ready low for exactly 16 cycles, high after edge k+16, msg_len=1.
REQ-030 Hash "AlessandroAndGiacomo" vs "AlessandroandGiacomo" -> digests differ; repeat first -> bit-identical digest; compare with the C reference model.
REQ-031 MSG in IDLE, TAIL in IDLE, cmd 11 in OPEN -> cmd_err pulses 3 times, digest/msg_len/state unchanged.
REQ-032 rst_n low at round 5 of a byte -> all outputs at reset values immediately; next HEAD+bytes+TAIL matches model.
REQ-033 With LIGHT_HASH_LEN_PAD_EN, N=4, ROUNDS=1: HEAD, TAIL -> one padding round with M=0, digest matches model, differs from 32'h7b777c63.
